insn_mem_ctrl: RTL and testbench

INSN_MEM_CTRL -- requirements
Module: insn_mem_ctrl

---
 rtl/insn_mem_ctrl.sv | 155 +++++++++++++++
 tb/tb_insn_mem_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/insn_mem_ctrl.sv
// Instruction memory controller: a burst loader fills a word-addressed RAM,
// and a single-cycle-latency fetch port reads it while the loader is idle.
module insn_mem_ctrl #(
    parameter int DEPTH  = 512,
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 11
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_start_i,
    input  logic [ADDR_W-1:0] load_base_i,
    input  logic [ADDR_W-2:0] load_len_i,
    input  logic              load_valid_i,
    input  logic [WIDTH-1:0]  load_data_i,
    output logic              load_ready_o,
    output logic              load_done_o,
    input  logic              fetch_req_i,
    input  logic [ADDR_W-1:0] fetch_addr_i,
    output logic              fetch_ready_o,
    output logic              fetch_valid_o,
    output logic [WIDTH-1:0]  fetch_data_o,
    output logic              fetch_err_o
);

    localparam int IDX_W = ADDR_W - 2;
    localparam logic [ADDR_W-2:0] LEN_ZERO = {(ADDR_W-1){1'b0}};
    localparam logic [ADDR_W-2:0] LEN_ONE  = {{(ADDR_W-2){1'b0}}, 1'b1};
    localparam logic [IDX_W-1:0]  IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        LOAD = 1'b1
    } state_t;

    state_t            state_r;
    state_t            next_state_s;
    logic [IDX_W-1:0]  wr_idx_r;
    logic [ADDR_W-2:0] remain_r;
    logic              load_done_r;
    logic              fetch_valid_r;
    logic [WIDTH-1:0]  fetch_data_r;
    logic              fetch_err_r;
    logic              load_ready_s;
    logic              fetch_ready_s;
    logic [WIDTH-1:0]  mem_r [DEPTH];

    logic start_s;
    logic zero_len_s;
    logic accept_s;
    logic last_s;
    logic fetch_acc_s;
    logic misalign_s;
    logic unused_s;

    // Byte offset of the load base carries no information for word storage.
    assign unused_s    = ^load_base_i[1:0];
    assign start_s     = (state_r == IDLE) && load_start_i;
    assign zero_len_s  = (load_len_i == LEN_ZERO);
    assign accept_s    = (state_r == LOAD) && load_valid_i;
    assign last_s      = accept_s && (remain_r == LEN_ONE);
    assign fetch_acc_s = fetch_ready_s && fetch_req_i;
    assign misalign_s  = |fetch_addr_i[1:0];

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (load_start_i && !zero_len_s) begin
                    next_state_s = LOAD;
                end else begin
                    next_state_s = IDLE;
                end
            end
            LOAD: begin
                if (last_s) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = LOAD;
                end
            end
            default: next_state_s = IDLE;
        endcase
    end

    // Handshake outputs decoded from the state register.
    always_comb begin
        load_ready_s  = 1'b0;
        fetch_ready_s = 1'b0;
        case (state_r)
            IDLE:    fetch_ready_s = 1'b1;
            LOAD:    load_ready_s  = 1'b1;
            default: fetch_ready_s = 1'b0;
        endcase
    end

    // Burst write pointer, remaining-word count and completion pulse.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_idx_r    <= {IDX_W{1'b0}};
            remain_r    <= LEN_ZERO;
            load_done_r <= 1'b0;
        end else begin
            load_done_r <= (start_s && zero_len_s) || last_s;
            if (start_s && !zero_len_s) begin
                wr_idx_r <= load_base_i[ADDR_W-1:2];
                remain_r <= load_len_i;
            end else if (accept_s) begin
                wr_idx_r <= wr_idx_r + IDX_ONE;
                remain_r <= remain_r - LEN_ONE;
            end
        end
    end

    // Storage array; wrap-around of the pointer comes from its width.
    always_ff @(posedge clk_i) begin
        if (accept_s) begin
            mem_r[wr_idx_r] <= load_data_i;
        end
    end

    // Fetch result register; holds its value until the next accepted fetch.
    // Writes only happen in LOAD and fetches only in IDLE, so reads never
    // collide with a write to the same word.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fetch_valid_r <= 1'b0;
            fetch_data_r  <= {WIDTH{1'b0}};
            fetch_err_r   <= 1'b0;
        end else begin
            fetch_valid_r <= fetch_acc_s;
            if (fetch_acc_s) begin
                fetch_err_r  <= misalign_s;
                fetch_data_r <= misalign_s ? {WIDTH{1'b0}} : mem_r[fetch_addr_i[ADDR_W-1:2]];
            end
        end
    end

    assign load_ready_o  = load_ready_s;
    assign load_done_o   = load_done_r;
    assign fetch_ready_o = fetch_ready_s;
    assign fetch_valid_o = fetch_valid_r;
    assign fetch_data_o  = fetch_data_r;
    assign fetch_err_o   = fetch_err_r;

endmodule

// File: tb/tb_insn_mem_ctrl.sv
// Directed bench for insn_mem_ctrl: a shadow memory predicts fetch results,
// which are queued at issue time and compared when fetch_valid_o returns.
module tb_insn_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_start = 1'b0;
    logic [10:0] load_base = 11'h000;
    logic [9:0]  load_len = 10'd0;
    logic        load_valid = 1'b0;
    logic [31:0] load_data = 32'h0;
    logic        load_ready;
    logic        load_done;
    logic        fetch_req = 1'b0;
    logic [10:0] fetch_addr = 11'h000;
    logic        fetch_ready;
    logic        fetch_valid;
    logic [31:0] fetch_data;
    logic        fetch_err;

    insn_mem_ctrl dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .load_start_i  (load_start),
        .load_base_i   (load_base),
        .load_len_i    (load_len),
        .load_valid_i  (load_valid),
        .load_data_i   (load_data),
        .load_ready_o  (load_ready),
        .load_done_o   (load_done),
        .fetch_req_i   (fetch_req),
        .fetch_addr_i  (fetch_addr),
        .fetch_ready_o (fetch_ready),
        .fetch_valid_o (fetch_valid),
        .fetch_data_o  (fetch_data),
        .fetch_err_o   (fetch_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        err;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model [512];
    logic [8:0]  cur_idx = 9'd0;
    bit          issued = 1'b0;
    logic [31:0] last_d = 32'h0;
    logic        last_e = 1'b0;
    int          tests = 0;
    int          failed = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic issue_fetch(input logic [10:0] a);
        exp_t e;
        fetch_req  = 1'b1;
        fetch_addr = a;
        e.err  = |a[1:0];
        e.data = e.err ? 32'h0 : model[a[10:2]];
        sb.push_back(e);
        issued = 1'b1;
    endtask

    // One clock: inputs set by the caller are sampled, then outputs checked.
    task automatic tick(input bit exp_done);
        exp_t e;
        bit   ev;
        @(posedge clk);
        #1;
        ev = issued;
        issued = 1'b0;
        fetch_req  = 1'b0;
        load_start = 1'b0;
        load_valid = 1'b0;
        chk("load_done", {63'd0, load_done}, {63'd0, exp_done});
        chk("fetch_valid", {63'd0, fetch_valid}, {63'd0, ev});
        if (ev) begin
            if (sb.size() == 0) begin
                chk("scoreboard_empty", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                last_d = e.data;
                last_e = e.err;
            end
        end
        chk("fetch_data", {32'd0, fetch_data}, {32'd0, last_d});
        chk("fetch_err", {63'd0, fetch_err}, {63'd0, last_e});
    endtask

    task automatic start(input logic [10:0] b, input logic [9:0] n, input bit exp_done);
        load_start = 1'b1;
        load_base  = b;
        load_len   = n;
        cur_idx    = b[10:2];
        tick(exp_done);
    endtask

    task automatic word(input bit v, input logic [31:0] d, input bit exp_done);
        load_valid = v;
        load_data  = d;
        if (v) begin
            model[cur_idx] = d;
            cur_idx = cur_idx + 9'd1;
        end
        tick(exp_done);
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_load_ready", {63'd0, load_ready}, 64'd0);
        chk("rst_fetch_ready", {63'd0, fetch_ready}, 64'd1);
        chk("rst_load_done", {63'd0, load_done}, 64'd0);
        chk("rst_fetch_valid", {63'd0, fetch_valid}, 64'd0);
        chk("rst_fetch_data", {32'd0, fetch_data}, 64'd0);
        chk("rst_fetch_err", {63'd0, fetch_err}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Plain burst of three words, then read them back
        start(11'h000, 10'd3, 1'b0);
        chk("load_ready_in_load", {63'd0, load_ready}, 64'd1);
        chk("fetch_ready_in_load", {63'd0, fetch_ready}, 64'd0);
        word(1'b1, 32'hAAAA_0001, 1'b0);
        word(1'b1, 32'hBBBB_0002, 1'b0);
        word(1'b1, 32'hCCCC_0003, 1'b1);
        chk("load_ready_after", {63'd0, load_ready}, 64'd0);
        tick(1'b0);
        issue_fetch(11'h000); tick(1'b0);
        issue_fetch(11'h004); tick(1'b0);
        issue_fetch(11'h008); tick(1'b0);
        tick(1'b0);

        // Burst wrapping from the last word to word 0
        start(11'h7FC, 10'd2, 1'b0);
        word(1'b1, 32'hDDDD_0004, 1'b0);
        word(1'b1, 32'hEEEE_0005, 1'b1);
        issue_fetch(11'h000); tick(1'b0);
        issue_fetch(11'h7FC); tick(1'b0);

        // Misaligned fetch, then result holds
        issue_fetch(11'h006); tick(1'b0);
        tick(1'b0);

        // Stalled burst with fetch attempts that must be refused
        start(11'h000, 10'd2, 1'b0);
        fetch_req = 1'b1;
        chk("stall_fetch_ready0", {63'd0, fetch_ready}, 64'd0);
        word(1'b1, 32'h1111_0006, 1'b0);
        fetch_req = 1'b1;
        chk("stall_load_ready", {63'd0, load_ready}, 64'd1);
        word(1'b0, 32'hDEAD_BEEF, 1'b0);
        fetch_req = 1'b1;
        chk("stall_fetch_ready1", {63'd0, fetch_ready}, 64'd0);
        word(1'b0, 32'hBAD0_BAD0, 1'b0);
        fetch_req = 1'b1;
        word(1'b1, 32'h2222_0007, 1'b1);
        issue_fetch(11'h000); tick(1'b0);
        issue_fetch(11'h004); tick(1'b0);
        issue_fetch(11'h008); tick(1'b0);

        // Zero-length load
        start(11'h040, 10'd0, 1'b1);
        chk("zero_len_ready", {63'd0, load_ready}, 64'd0);
        tick(1'b0);
        chk("zero_len_fetch_ready", {63'd0, fetch_ready}, 64'd1);

        // Load start coinciding with a fetch
        issue_fetch(11'h004);
        start(11'h010, 10'd1, 1'b0);
        chk("coincide_load_ready", {63'd0, load_ready}, 64'd1);
        word(1'b1, 32'h3333_0008, 1'b1);
        issue_fetch(11'h010); tick(1'b0);

        // Reset in the middle of a burst (base offset bits ignored)
        start(11'h103, 10'd4, 1'b0);
        word(1'b1, 32'h4444_0009, 1'b0);
        rst_n = 1'b0;
        #2;
        chk("midrst_load_ready", {63'd0, load_ready}, 64'd0);
        chk("midrst_fetch_ready", {63'd0, fetch_ready}, 64'd1);
        chk("midrst_load_done", {63'd0, load_done}, 64'd0);
        chk("midrst_fetch_data", {32'd0, fetch_data}, 64'd0);
        last_d = 32'h0;
        last_e = 1'b0;
        rst_n = 1'b1;
        tick(1'b0);
        tick(1'b0);
        tick(1'b0);
        chk("postrst_load_ready", {63'd0, load_ready}, 64'd0);
        issue_fetch(11'h100); tick(1'b0);
        tick(1'b0);

        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
